display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a bank of common-cathode 7-segment digits driven by the 8-bit counter.
//  Holds a shadow copy of the packed BCD value and steps through the digits one at a time.
//  For each digit it drives a one-hot select and the decoded 8-bit segment pattern, with a blanking gap between digits.
//  Sits between the counter/BCD converter and the board's digit-select and segment pins.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; 2..8
//  DWELL_CYCLES  50000  clk cycles a digit is lit; >=1
//  BLANK_CYCLES  500    clk cycles all digits are off before each digit; >=1
// PORTS
//  clk        in   1             system clock; single clock domain
//  rst_n      in   1             synchronous reset, active-low
//  en         in   1             1 = scanning, 0 = display off (IDLE)
//  lzb        in   1             1 = leading-zero blanking enabled
//  bcd_data   in   4*NUM_DIGITS  packed BCD; digit k = bcd_data[4k+3:4k]; digit 0 = LSD
//  load_req   in   1             request to latch bcd_data; held high until load_ack
//  load_ack   out  1             1-cycle pulse: bcd_data captured into shadow
//  digit_sel  out  NUM_DIGITS    one-hot, active-high; bit k lights digit k
//  seg_out    out  8             segments {a,b,c,d,e,f,g,dp}, active-high
//  frame_done out  1             1-cycle pulse at end of the last digit's dwell
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE, digit index=0, shadow=0, both timers=0
//   - digit_sel=0, seg_out=8'h00, load_ack=0, frame_done=0
//  Registered outputs: digit_sel and seg_out change on the same edge; no output glitch between them.
//  FSM states: IDLE, BLANK, SHOW.
//  IDLE:
//   - digit_sel=0, seg_out=0
//   - en=1 -> BLANK with index=0
//   - load_req=1 -> shadow<=bcd_data and load_ack=1 on the next cycle; this applies only while en=0
//  BLANK:
//   - digit_sel=0, seg_out=0 for BLANK_CYCLES cycles -> SHOW
//  SHOW:
//   - digit_sel=1<<index, seg_out=decode(shadow digit) for DWELL_CYCLES cycles
//   - then index+1 -> BLANK
//   - at index NUM_DIGITS-1: wrap index to 0, pulse frame_done in the final SHOW cycle
//  en=0 in any state -> IDLE next cycle, with outputs off. The frame is abandoned; a later en=1 restarts at digit 0.
//  Frame length = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles exactly.
//  Load handshake while scanning:
//   - load_req is sampled only in the final SHOW cycle of the last digit (frame boundary), which prevents tearing
//   - if load_req=1 there: shadow<=bcd_data, and load_ack pulses on the following cycle
//   - requester holds bcd_data stable while load_req=1 and drops load_req after seeing load_ack
//   - load_ack is never high two consecutive cycles; load_req held through ack is not re-accepted until the next boundary
//  Decode:
//   - 0..9 map to the standard pattern (0=8'hFC, 1=8'h60, ... 8=8'hFE, 9=8'hF6)
//   - values 10..15 give seg_out=8'h00, never X
//  Leading-zero blanking (lzb=1):
//   - digit k with value 0 shows 8'h00 when all digits above k are 0
//   - digit 0 is always shown
//   - timing and digit_sel are unchanged by blanking
//  lzb and en are sampled live; a change takes effect on the next digit boundary (lzb) or next cycle (en).
//  Timer widths are derived with $clog2 of each parameter; no counter overflows for legal parameter values.
// STRUCTURE
//  Shared package/include (display_pkg):
//   - state encodings ST_IDLE/ST_BLANK/ST_SHOW
//   - SEG_BLANK=8'h00
//   - the 8-bit segment-order definition
//  One sub-module: an instance of the team's BCD-to-7-segment decoder, bcd_coder, on the selected digit.
//   - its output is masked to SEG_BLANK for invalid or blanked digits, then registered
//  The rest stays in one file: FSM, dwell/blank timer, digit index, shadow register, LZB mask.
// TESTING (bench: NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=1)
//  1 Reset: rst_n low 3 cycles, en=1 -> digit_sel=0, seg_out=00, load_ack=0, frame_done=0 throughout.
//  2 Load in IDLE: bcd_data=16'h1234, load_req=1 -> load_ack next cycle; en=1 ->
//    per digit 1 blank + 4 lit cycles; digit_sel 0001/0010/0100/1000; seg 0x66,0xF2,0xDA,0x60;
//    frame_done once every 20 cycles.
//  3 Mid-frame load: bcd_data=16'h0987, load_req asserted at digit 1 ->
//    no ack until the last SHOW cycle of digit 3; next frame shows 7,8,9,0.
//  4 LZB: shadow=16'h0050, lzb=1 -> digit0=0xFC, digit1=0xB6, digits 2,3=0x00, digit_sel timing unchanged;
//    shadow=0 -> only digit 0 shows 0xFC.
//  5 Invalid BCD: digit value 4'hB -> seg_out=0x00 during its SHOW, never X.
//  6 en dropped during SHOW of digit 2 -> next cycle IDLE, outputs 0; en=1 again -> restarts at digit 0 after 1 blank cycle.
//    rst_n pulsed mid-frame -> shadow cleared to 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared FSM encodings and segment layout for the 7-segment scan path.
package display_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;
    // Bit 7 is segment a, bit 0 is the decimal point.
    typedef struct packed {logic a, b, c, d, e, f, g, dp;} seg_t;
    localparam seg_t SEG_BLANK = 8'h00;
endpackage

// File: rtl/bcd_coder.sv
// bcd_coder: BCD digit to active-high 7-segment pattern; valid flags 0..9.
module bcd_coder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg,
    output logic       valid
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = 8'hFC;
            4'd1: seg = 8'h60;
            4'd2: seg = 8'hDA;
            4'd3: seg = 8'hF2;
            4'd4: seg = 8'h66;
            4'd5: seg = 8'hB6;
            4'd6: seg = 8'hBE;
            4'd7: seg = 8'hE0;
            4'd8: seg = 8'hFE;
            4'd9: seg = 8'hF6;
            default: seg = SEG_BLANK;
        endcase
    end
    assign valid = bcd <= 4'd9;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scanner with shadowed BCD value,
// blanking gaps, leading-zero blanking and a frame-boundary load handshake.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    lzb,
    input  logic [4*NUM_DIGITS-1:0] bcd_data,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [7:0]              seg_out,
    output logic                    frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLANK_CYCLES - 1);

    state_t state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [DW-1:0] dtmr, dtmr_nxt;
    logic [BW-1:0] btmr, btmr_nxt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic load, zero_above, seg_valid;
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [3:0] digit;
    logic [7:0] seg_lit;
    seg_t seg_raw;

    assign digit = 4'(shadow >> {idx_nxt, 2'b00});

    bcd_coder u_coder (.bcd(digit), .seg(seg_raw), .valid(seg_valid));

    // lz_mask[k] is set when digit k and every digit above it are zero.
    always_comb begin
        zero_above = 1'b1;
        lz_mask = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above && (shadow[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_above;
        end
    end

    assign seg_lit = (!seg_valid || (lzb && lz_mask[idx_nxt])) ? SEG_BLANK : seg_raw;

    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        dtmr_nxt = dtmr;
        btmr_nxt = btmr;
        load = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
            idx_nxt = '0;
            dtmr_nxt = '0;
            btmr_nxt = '0;
            load = state == ST_IDLE && load_req && !load_ack;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_BLANK;
                ST_BLANK: begin
                    state_nxt = btmr == B_LAST ? ST_SHOW : ST_BLANK;
                    btmr_nxt = btmr == B_LAST ? '0 : btmr + 1'b1;
                end
                default: begin
                    state_nxt = dtmr == D_LAST ? ST_BLANK : ST_SHOW;
                    dtmr_nxt = dtmr == D_LAST ? '0 : dtmr + 1'b1;
                    idx_nxt = dtmr != D_LAST ? idx : idx == IDX_LAST ? '0 : idx + 1'b1;
                    // The shadow only changes at the frame boundary, so a frame never tears.
                    load = dtmr == D_LAST && idx == IDX_LAST && load_req;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx <= '0;
            dtmr <= '0;
            btmr <= '0;
            shadow <= '0;
            load_ack <= 1'b0;
            digit_sel <= '0;
            seg_out <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            dtmr <= dtmr_nxt;
            btmr <= btmr_nxt;
            shadow <= load ? bcd_data : shadow;
            load_ack <= load;
            digit_sel <= state_nxt == ST_SHOW ? NUM_DIGITS'(1) << idx_nxt : '0;
            // Pattern (and lzb) is captured on entry to SHOW and held for the whole dwell.
            seg_out <= state_nxt != ST_SHOW ? SEG_BLANK : state != ST_SHOW ? seg_lit : seg_out;
            frame_done <= state_nxt == ST_SHOW && idx_nxt == IDX_LAST && dtmr_nxt == D_LAST;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed and random stimulus against a frame-position reference model.
module tb_display_scan_ctrl;
    localparam int ND = 4;
    localparam int DWL = 4;
    localparam int BLK = 1;
    localparam int SLOT = BLK + DWL;
    localparam int FRAME = ND * SLOT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic lzb = 1'b0;
    logic [15:0] bcd_data = '0;
    logic load_req = 1'b0;
    logic load_ack, frame_done;
    logic [ND-1:0] digit_sel;
    logic [7:0] seg_out;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] pat [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    bit m_run = 0;
    int m_p = 0;
    logic [15:0] m_sh = '0;
    bit m_ack = 0;
    logic [7:0] m_lit = '0;
    logic [ND-1:0] e_sel;
    logic [7:0] e_seg;
    bit e_fd;

    display_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DWL), .BLANK_CYCLES(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lzb(lzb), .bcd_data(bcd_data),
        .load_req(load_req), .load_ack(load_ack), .digit_sel(digit_sel),
        .seg_out(seg_out), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg(int d, logic [15:0] sh, logic lz);
        logic [3:0] v;
        v = sh[4*d +: 4];
        if (v > 4'd9) return 8'h00;
        if (lz && d > 0 && (sh >> (4 * d)) == 16'h0) return 8'h00;
        return pat[v];
    endfunction

    // Model tracks position within the frame; p is the index of the upcoming cycle.
    task automatic model_step();
        bit a;
        a = 0;
        if (!rst_n) begin
            m_run = 0;
            m_p = 0;
            m_sh = '0;
        end else if (!en) begin
            if (!m_run && load_req && !m_ack) begin
                m_sh = bcd_data;
                a = 1;
            end
            m_run = 0;
            m_p = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_p = 0;
        end else if (m_p == FRAME - 1) begin
            if (load_req) begin
                m_sh = bcd_data;
                a = 1;
            end
            m_p = 0;
        end else begin
            m_p++;
        end
        m_ack = a;
        e_sel = '0;
        e_seg = 8'h00;
        e_fd = 0;
        if (rst_n && m_run && m_p % SLOT >= BLK) begin
            if (m_p % SLOT == BLK) m_lit = exp_seg(m_p / SLOT, m_sh, lzb);
            e_sel = ND'(1) << (m_p / SLOT);
            e_seg = m_lit;
            e_fd = m_p == FRAME - 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("digit_sel", 32'(digit_sel), 32'(e_sel));
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("load_ack", 32'(load_ack), 32'(m_ack));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic load(input logic [15:0] v, output int n);
        bcd_data = v;
        load_req = 1'b1;
        n = 0;
        while (n < 60) begin
            tick();
            n++;
            if (load_ack) break;
        end
        check("load_ack_seen", 32'(load_ack), 32'd1);
        load_req = 1'b0;
    endtask

    task automatic wait_sel(input logic [ND-1:0] s);
        int i;
        for (i = 0; i < 100 && digit_sel !== s; i++) tick();
        check("wait_sel_timeout", 32'(digit_sel), 32'(s));
    endtask

    initial begin
        int n, fd_cnt, fd_first;
        rst_n = 1'b0;
        en = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        load(16'h1234, n);
        check("idle_ack_latency", 32'(n), 32'd1);
        en = 1'b1;
        fd_cnt = 0;
        fd_first = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (frame_done) begin
                fd_cnt++;
                if (fd_first == 0) fd_first = i;
            end
        end
        check("frame_done_count", 32'(fd_cnt), 32'd2);
        check("frame_done_first", 32'(fd_first), 32'(FRAME));
        wait_sel(4'b0010);
        load(16'h0987, n);
        check("boundary_ack_latency", 32'(n), 32'(FRAME - SLOT - BLK));
        repeat (FRAME + 2) tick();
        en = 1'b0;
        tick();
        load(16'h0050, n);
        lzb = 1'b1;
        en = 1'b1;
        repeat (FRAME + 2) tick();
        en = 1'b0;
        tick();
        load(16'h0000, n);
        en = 1'b1;
        repeat (FRAME + 2) tick();
        en = 1'b0;
        lzb = 1'b0;
        tick();
        load(16'h00B0, n);
        en = 1'b1;
        wait_sel(4'b0010);
        check("invalid_bcd_blank", 32'(seg_out), 32'h0);
        wait_sel(4'b0100);
        tick();
        en = 1'b0;
        tick();
        check("en_drop_off", 32'({digit_sel, seg_out}), 32'h0);
        en = 1'b1;
        repeat (BLK + 2) tick();
        check("restart_digit0", 32'(digit_sel), 32'b0001);
        repeat (7) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (FRAME + 2) tick();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) lzb = ~lzb;
            if (load_req && load_ack) load_req = 1'b0;
            else if (!load_req && $urandom_range(0, 29) == 0) begin
                load_req = 1'b1;
                bcd_data = 16'($urandom);
            end
            rst_n = $urandom_range(0, 499) != 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
